gf_pow_engine: RTL and testbench

Parametrised GF(2^SYM_W) exponentiation engine using right-to-left square-and-multiply with one shared combinational field multiplier. It computes base^exp, or the multiplicative inverse base^(2^SYM_W-2) in inverse mode. It uses a start/ready/done handshake. It serves the Reed-Solomon decoder's syndrome, Forney and error-magnitude stages, which need powers of alpha and field inverses.

---
 rtl/gf_pkg.sv | 19 +
 rtl/gf_mul.sv | 27 ++
 rtl/gf_pow_engine.sv | 119 +++++++++++
 tb/tb_gf_pow_engine.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared GF(2^m) definitions for the Reed-Solomon decoder blocks.
// Holds field defaults, the exponentiation FSM state type and the inverse-exponent helper.
package gf_pkg;

  localparam int DEF_SYM_W = 8;
  localparam logic [8:0] DEF_PRIM_POLY = 9'h11D;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } gf_state_t;

  // a^(2^m - 2) is the multiplicative inverse of a in GF(2^m)
  function automatic int gf_inv_exp(input int sym_w);
    return (1 << sym_w) - 2;
  endfunction

endpackage

// File: rtl/gf_mul.sv
// Combinational GF(2^SYM_W) multiplier: shift-and-xor product reduced modulo PRIM_POLY.
module gf_mul
  import gf_pkg::*;
#(
  parameter int SYM_W = DEF_SYM_W,
  parameter logic [SYM_W:0] PRIM_POLY = DEF_PRIM_POLY
) (
  input  logic [SYM_W-1:0] a,
  input  logic [SYM_W-1:0] b,
  output logic [SYM_W-1:0] p
);

  logic [SYM_W-1:0] sum;
  logic [SYM_W-1:0] shifted;

  // shifted tracks a*x^i, reduced each step so it never leaves the field
  always_comb begin
    sum = '0;
    shifted = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) sum = sum ^ shifted;
      shifted = {shifted[SYM_W-2:0], 1'b0} ^ (shifted[SYM_W-1] ? PRIM_POLY[SYM_W-1:0] : '0);
    end
    p = sum;
  end

endmodule

// File: rtl/gf_pow_engine.sv
// Right-to-left square-and-multiply exponentiation in GF(2^SYM_W) with one shared multiplier.
// Computes base^exp, or the field inverse base^(2^SYM_W-2) in inverse mode.
module gf_pow_engine
  import gf_pkg::*;
#(
  parameter int SYM_W = DEF_SYM_W,
  parameter int EXP_W = 8,
  parameter logic [SYM_W:0] PRIM_POLY = DEF_PRIM_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [SYM_W-1:0] base_in,
  input  logic [EXP_W-1:0] exp_in,
  output logic             ready,
  output logic             done,
  output logic [SYM_W-1:0] result,
  output logic             inv_err
);

  localparam logic [EXP_W-1:0] INV_EXP = EXP_W'(gf_inv_exp(SYM_W));

  gf_state_t state, state_nxt;
  logic [SYM_W-1:0] base_reg, base_nxt;
  logic [EXP_W-1:0] exp_reg, exp_nxt;
  logic [SYM_W-1:0] acc, acc_nxt;
  logic [SYM_W-1:0] result_nxt;
  logic mul_pending, mul_pending_nxt;
  logic err_pending, err_pending_nxt;
  logic inv_err_nxt;
  logic done_nxt;
  logic mul_step;
  logic [SYM_W-1:0] mul_a;
  logic [SYM_W-1:0] mul_p;

  // The single multiplier either folds base into acc or squares base
  assign mul_step = (state == RUN) && (exp_reg != '0) && exp_reg[0] && !mul_pending;
  assign mul_a = mul_step ? acc : base_reg;

  gf_mul #(
    .SYM_W(SYM_W),
    .PRIM_POLY(PRIM_POLY)
  ) u_mul (
    .a(mul_a),
    .b(base_reg),
    .p(mul_p)
  );

  assign ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      base_reg <= '0;
      exp_reg <= '0;
      acc <= '0;
      mul_pending <= 1'b0;
      err_pending <= 1'b0;
      result <= '0;
      inv_err <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      base_reg <= base_nxt;
      exp_reg <= exp_nxt;
      acc <= acc_nxt;
      mul_pending <= mul_pending_nxt;
      err_pending <= err_pending_nxt;
      result <= result_nxt;
      inv_err <= inv_err_nxt;
      done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    base_nxt = base_reg;
    exp_nxt = exp_reg;
    acc_nxt = acc;
    mul_pending_nxt = mul_pending;
    err_pending_nxt = err_pending;
    result_nxt = result;
    inv_err_nxt = inv_err;
    done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          base_nxt = base_in;
          acc_nxt = SYM_W'(1);
          exp_nxt = mode ? INV_EXP : exp_in;
          mul_pending_nxt = 1'b0;
          // inv_err must not show until done, so the zero-inverse case is parked here
          err_pending_nxt = mode && (base_in == '0);
          inv_err_nxt = 1'b0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (exp_reg == '0) begin
          result_nxt = acc;
          inv_err_nxt = err_pending;
          done_nxt = 1'b1;
          state_nxt = DONE;
        end else if (mul_step) begin
          acc_nxt = mul_p;
          mul_pending_nxt = 1'b1;
        end else begin
          base_nxt = mul_p;
          exp_nxt = exp_reg >> 1;
          mul_pending_nxt = 1'b0;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gf_pow_engine.sv
// Self-checking bench for gf_pow_engine against a repeated-multiplication GF(2^8) model.
module tb_gf_pow_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic [7:0] base_in = '0;
  logic [7:0] exp_in = '0;
  logic ready;
  logic done;
  logic [7:0] result;
  logic inv_err;

  int checks = 0;
  int errors = 0;

  gf_pow_engine #(.SYM_W(8), .EXP_W(8), .PRIM_POLY(9'h11D)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mode(mode),
    .base_in(base_in),
    .exp_in(exp_in),
    .ready(ready),
    .done(done),
    .result(result),
    .inv_err(inv_err)
  );

  always #5 clk = ~clk;

  // Carry-less product followed by long-division reduction by x^8+x^4+x^3+x^2+1
  function automatic logic [7:0] refMul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h11D << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] refPow(input logic [7:0] b, input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < e; i++) r = refMul(r, b);
    return r;
  endfunction

  function automatic int refLatency(input int e);
    int len;
    len = 0;
    for (int i = 0; i < 32; i++) if ((e >> i) != 0) len = i + 1;
    return $countones(e) + len + 2;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Launches one operation, counts edges to done and checks result, flag, latency and pulse width
  task automatic applyStimulus(input string tag, input logic m, input logic [7:0] b, input logic [7:0] e);
    int eff;
    int edges;
    eff = m ? 254 : int'(e);
    @(negedge clk);
    start = 1'b1;
    mode = m;
    base_in = b;
    exp_in = e;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = $urandom_range(1);
    base_in = 8'($urandom);
    exp_in = 8'($urandom);
    edges = 1;
    while (!done && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_latency"}, edges, refLatency(eff));
    checkOutput({tag, "_result"}, 32'(result), 32'(refPow(b, eff)));
    checkOutput({tag, "_inv_err"}, 32'(inv_err), 32'(m && b == 8'h00));
    checkOutput({tag, "_ready_in_done"}, 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_ready_after"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int done_count;
    logic [7:0] held;
    $display("[TB] gf_pow_engine bench starting");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", 32'(result), 32'd0);
    checkOutput("reset_inv_err", 32'(inv_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("pow_2_8", 1'b0, 8'h02, 8'd8);
    checkOutput("pow_2_8_const", 32'(result), 32'h1D);
    applyStimulus("inv_02", 1'b1, 8'h02, 8'd0);
    checkOutput("inv_02_const", 32'(result), 32'h8E);
    applyStimulus("inv_8e", 1'b1, 8'h8E, 8'd77);
    checkOutput("inv_8e_const", 32'(result), 32'h02);
    applyStimulus("pow_2_255", 1'b0, 8'h02, 8'd255);
    checkOutput("pow_2_255_const", 32'(result), 32'h01);
    applyStimulus("zero_pow_zero", 1'b0, 8'h00, 8'd0);
    checkOutput("zero_pow_zero_const", 32'(result), 32'h01);
    applyStimulus("zero_pow_5", 1'b0, 8'h00, 8'd5);
    applyStimulus("inv_zero", 1'b1, 8'h00, 8'd0);
    checkOutput("inv_zero_flag", 32'(inv_err), 32'd1);
    applyStimulus("inv_03", 1'b1, 8'h03, 8'd0);

    // A start pulsed mid-run must be dropped without disturbing the running operation
    held = result;
    @(negedge clk);
    start = 1'b1;
    mode = 1'b0;
    base_in = 8'h02;
    exp_in = 8'd8;
    @(negedge clk);
    base_in = 8'h05;
    exp_in = 8'd3;
    mode = 1'b1;
    checkOutput("busy_result_stable", 32'(result), 32'(held));
    @(negedge clk);
    start = 1'b0;
    done_count = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) done_count++;
    end
    checkOutput("busy_done_count", done_count, 1);
    checkOutput("busy_result", 32'(result), 32'h1D);

    // Reset in the middle of an inverse computation
    @(negedge clk);
    start = 1'b1;
    mode = 1'b1;
    base_in = 8'h02;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrun_rst_ready", 32'(ready), 32'd1);
    checkOutput("midrun_rst_done", 32'(done), 32'd0);
    checkOutput("midrun_rst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("after_rst", 1'b0, 8'h03, 8'd2);
    checkOutput("after_rst_const", 32'(result), 32'h05);

    for (int n = 0; n < 20; n++) begin
      logic m;
      logic [7:0] b;
      logic [7:0] e;
      m = ($urandom_range(3) == 0);
      b = 8'($urandom);
      e = 8'($urandom);
      applyStimulus($sformatf("rand%0d", n), m, b, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
